counter_arb: RTL

COUNTER_ARB -- requirements
Module: counter_arb

---
 rtl/counter_arb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 28 ++
 rtl/counter_arb.sv | 115 +++++++++++
 3 files changed

// File: rtl/counter_arb_pkg.sv
// Shared types and widths for the two-master counter read arbiter.
package counter_arb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int LAT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the most recently granted master.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 means master 1 was granted last, so master 0 wins the first tie
    logic r_last;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            r_last <= grant[1];
        end
    end

endmodule

// File: rtl/counter_arb.sv
// Arbitrates two read masters onto one counter slave with READ_LAT read latency.
// Optional grant statistics ports are enabled by defining COUNTER_ARB_STATS_EN.
module counter_arb
    import counter_arb_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m0_read,
    input  logic              m1_read,
    output logic [DATA_W-1:0] m0_readdata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m0_waitrequest,
    output logic              m1_waitrequest,
    output logic              m0_readdatavalid,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    input  logic [DATA_W-1:0] s_readdata
`ifdef COUNTER_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_winner;
    logic [ADDR_W-1:0]   r_addr;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic [1:0]          w_grant;
    logic                w_advance;
    logic                w_capture;

    assign w_advance = (r_state == IDLE) && (m0_read || m1_read);
    assign w_capture = (r_state == WAIT) && (r_lat_cnt == '0);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({m1_read, m0_read}),
        .advance (w_advance),
        .grant   (w_grant)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_advance) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (r_lat_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_winner  <= 1'b0;
            r_addr    <= '0;
            r_lat_cnt <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Winner and address are frozen here; later address changes are ignored
            if (w_advance) begin
                r_winner <= w_grant[1];
                r_addr   <= w_grant[1] ? m1_address : m0_address;
            end
            if (r_state == ISSUE) begin
                r_lat_cnt <= LAT_W'(READ_LAT - 1);
            end else if ((r_state == WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
            if (w_capture && !r_winner) r_rdata0 <= s_readdata;
            if (w_capture &&  r_winner) r_rdata1 <= s_readdata;
        end
    end

    assign s_read           = (r_state == ISSUE);
    assign s_address        = r_addr;
    assign m0_readdata      = r_rdata0;
    assign m1_readdata      = r_rdata1;
    assign m0_readdatavalid = (r_state == DONE) && !r_winner;
    assign m1_readdatavalid = (r_state == DONE) &&  r_winner;
    assign m0_waitrequest   = m0_read && !m0_readdatavalid;
    assign m1_waitrequest   = m1_read && !m1_readdatavalid;

`ifdef COUNTER_ARB_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
        end else begin
            if (m0_readdatavalid && (r_grant_cnt0 != 16'hFFFF)) r_grant_cnt0 <= r_grant_cnt0 + 1'b1;
            if (m1_readdatavalid && (r_grant_cnt1 != 16'hFFFF)) r_grant_cnt1 <= r_grant_cnt1 + 1'b1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule
